posit_encoder: RTL and testbench



---
 rtl/posit_encoder.sv | 177 +++++++++++++++++
 tb/tb_posit_encoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_encoder.sv
// posit_encoder: two-stage pipelined posit packer.
// Turns a decoded posit (sign, regime k, exponent, fraction, special flags)
// into the packed N-bit posit word. It rounds to nearest even, saturates at
// minpos/maxpos and applies two's-complement negation.
// S1 builds the regime run and splits the body into p/guard/sticky.
// S2 rounds, clamps, negates and handles the zero/NaR specials.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           input handshake
//   in_sign, in_k, in_exp,
//   in_frac, in_zero, in_nar    decoded posit fields (in_nar overrides in_zero)
//   out_valid/out_ready         output handshake
//   out_posit                   packed posit word
module posit_encoder #(
   parameter int unsigned N  = 16,
   parameter int unsigned ES = 1,
   parameter int unsigned FW = 16,
   parameter int unsigned KW = $clog2(N) + 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_sign,
   input  logic [KW-1:0] in_k,
   input  logic [ES-1:0] in_exp,
   input  logic [FW-1:0] in_frac,
   input  logic          in_zero,
   input  logic          in_nar,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_posit
);

   localparam int unsigned PW = N - 1;
   // Body seed {lead, terminator, exp, frac} plus N pad bits, so no bit
   // is shifted out before the sticky OR sees it.
   localparam int unsigned BW = 2 + ES + FW + N;
   localparam logic signed [KW-1:0] KHI = KW'(N - 2);
   localparam logic signed [KW-1:0] KLO = -KHI;

   logic          s1_valid_q, s1_valid_d;
   logic [PW-1:0] s1_p_q, s1_p_d;
   logic          s1_g_q, s1_g_d;
   logic          s1_s_q, s1_s_d;
   logic          s1_sign_q, s1_sign_d;
   logic          s1_zero_q, s1_zero_d;
   logic          s1_nar_q, s1_nar_d;
   logic          s2_valid_q, s2_valid_d;
   logic [N-1:0]  s2_posit_q, s2_posit_d;

   logic s1_adv, s2_adv;

   // Handshake: a stage advances when it is empty or its consumer advances.
   assign s2_adv   = ~s2_valid_q | out_ready;
   assign s1_adv   = ~s1_valid_q | s2_adv;
   assign in_ready = s1_adv;

   // S1: regime construction
   logic signed [KW-1:0] k_s, k_c;
   logic                 lead;
   logic [KW-1:0]        run_m1;
   logic signed [BW-1:0] body_seed, body;
   logic [PW-1:0]        p_c;
   logic                 g_c, s_c;

   always_comb begin
      k_s = $signed(in_k);
      k_c = k_s;
      if (k_s > KHI) begin
         k_c = KHI;
      end else if (k_s < KLO) begin
         k_c = KLO;
      end
      lead = ~k_c[KW-1];
      // Run length minus one: k for k >= 0, -k-1 (== ~k) for k < 0.
      run_m1    = lead ? $unsigned(k_c) : ~$unsigned(k_c);
      body_seed = {lead, ~lead, in_exp, in_frac, N'(0)};
      // Arithmetic shift replicates the lead bit into the full regime run.
      body = body_seed >>> run_m1;
      p_c  = body[BW-1 -: PW];
      g_c  = body[BW-1-PW];
      s_c  = |body[BW-2-PW:0];
      // Most negative regime always lands on minpos, whatever exp/frac hold.
      if (k_c == KLO) begin
         p_c = PW'(1);
         g_c = 1'b0;
         s_c = 1'b0;
      end
   end

   // S2: round to nearest even, saturate, negate, specials
   logic         round_up;
   logic [N-1:0] p_inc;
   logic [PW-1:0] p_sat;
   logic [N-1:0] w_c, word_c;

   always_comb begin
      round_up = s1_g_q & (s1_s_q | s1_p_q[0]);
      p_inc    = {1'b0, s1_p_q} + N'(round_up);
      if (p_inc[N-1]) begin
         p_sat = {PW{1'b1}};
      end else if (p_inc == '0) begin
         p_sat = PW'(1);
      end else begin
         p_sat = p_inc[PW-1:0];
      end
      w_c = {1'b0, p_sat};
      if (s1_nar_q) begin
         word_c = {1'b1, {PW{1'b0}}};
      end else if (s1_zero_q) begin
         word_c = '0;
      end else if (s1_sign_q) begin
         word_c = N'(0) - w_c;
      end else begin
         word_c = w_c;
      end
   end

   // Next-state for both stages; held data is only replaced on advance.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_p_d     = s1_p_q;
      s1_g_d     = s1_g_q;
      s1_s_d     = s1_s_q;
      s1_sign_d  = s1_sign_q;
      s1_zero_d  = s1_zero_q;
      s1_nar_d   = s1_nar_q;
      s2_valid_d = s2_valid_q;
      s2_posit_d = s2_posit_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_p_d    = p_c;
            s1_g_d    = g_c;
            s1_s_d    = s_c;
            s1_sign_d = in_sign;
            s1_zero_d = in_zero;
            s1_nar_d  = in_nar;
         end
      end
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_posit_d = word_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_p_q     <= '0;
         s1_g_q     <= 1'b0;
         s1_s_q     <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_zero_q  <= 1'b0;
         s1_nar_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_posit_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_p_q     <= s1_p_d;
         s1_g_q     <= s1_g_d;
         s1_s_q     <= s1_s_d;
         s1_sign_q  <= s1_sign_d;
         s1_zero_q  <= s1_zero_d;
         s1_nar_q   <= s1_nar_d;
         s2_valid_q <= s2_valid_d;
         s2_posit_q <= s2_posit_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_posit = s2_posit_q;

endmodule

// File: tb/tb_posit_encoder.sv
// tb_posit_encoder: self-checking bench for posit_encoder (N=16, ES=1, FW=16).
// Directed vectors use hand-derived words. Random traffic is checked against
// a bit-list reference model. A monitor compares every emitted word, and
// checks held words, against an expected-word queue.
`timescale 1ns/1ps
module tb_posit_encoder;

   localparam int unsigned N  = 16;
   localparam int unsigned ES = 1;
   localparam int unsigned FW = 16;
   localparam int unsigned KW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          in_sign;
   logic [KW-1:0] in_k;
   logic [ES-1:0] in_exp;
   logic [FW-1:0] in_frac;
   logic          in_zero;
   logic          in_nar;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_posit;

   int n_checks = 0;
   int n_pass   = 0;
   int occ      = 0;
   logic [15:0] exp_q[$];
   logic [15:0] cur_exp;

   posit_encoder #(.N(N), .ES(ES), .FW(FW), .KW(KW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_k      (in_k),
      .in_exp    (in_exp),
      .in_frac   (in_frac),
      .in_zero   (in_zero),
      .in_nar    (in_nar),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_posit (out_posit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] req);
      n_checks++;
      assert (got === req) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, got, req);
   endtask

   // Reference: spell out the body as a list of bits, then round on integers.
   function automatic logic [15:0] ref_posit(input bit sg, input int k, input int e,
                                             input int f, input bit z, input bit n);
      bit q[$];
      int kk, p, w;
      bit g, s;
      if (n) return 16'h8000;
      if (z) return 16'h0000;
      kk = (k > 14) ? 14 : ((k < -14) ? -14 : k);
      if (kk >= 0) begin
         repeat (kk + 1) q.push_back(1'b1);
         q.push_back(1'b0);
      end else begin
         repeat (-kk) q.push_back(1'b0);
         q.push_back(1'b1);
      end
      q.push_back(bit'(e & 1));
      for (int i = 15; i >= 0; i--) q.push_back(bit'((f >> i) & 1));
      p = 0;
      for (int i = 0; i < 15; i++) p = p * 2 + int'(q[i]);
      g = q[15];
      s = 1'b0;
      for (int i = 16; i < q.size(); i++) s = s | q[i];
      if (kk == -14) begin
         p = 1; g = 1'b0; s = 1'b0;
      end
      if (g && (s || (p % 2 == 1))) p++;
      if (p > 32767) p = 32767;
      if (p < 1) p = 1;
      w = sg ? (65536 - p) : p;
      return 16'(w);
   endfunction

   task automatic drive(input bit v, input bit sg, input int k, input int e,
                        input int f, input bit z, input bit n);
      in_valid = v;
      in_sign  = sg;
      in_k     = KW'(k);
      in_exp   = ES'(e);
      in_frac  = FW'(f);
      in_zero  = z;
      in_nar   = n;
   endtask

   // Output monitor: transferred words must match the queue head in order;
   // a stalled word must equal the head and stay put.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", out_posit, 16'hxxxx);
         end else if (out_ready) begin
            chk("out_word", out_posit, exp_q.pop_front());
         end else begin
            chk("stall_hold", out_posit, exp_q[0]);
         end
      end
   end

   // Single word into an empty pipe: checks acceptance and 2-cycle latency.
   task automatic directed(input string tag, input bit sg, input int k, input int e,
                           input int f, input bit z, input bit n, input logic [15:0] req);
      drive(1'b1, sg, k, e, f, z, n);
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_ready"}, 16'(in_ready), 16'(1));
      @(posedge clk);
      exp_q.push_back(req);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_lat1"}, 16'(out_valid), 16'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({tag, "_lat2"}, 16'(out_valid), 16'(1));
      @(posedge clk);
      #1;
   endtask

   // One streaming cycle; expected in_ready comes from the occupancy count.
   task automatic step(input bit v, input bit sg, input int k, input int e, input int f,
                       input bit z, input bit n, input bit ordy, output bit acc);
      bit fire;
      drive(v, sg, k, e, f, z, n);
      cur_exp = ref_posit(sg, k, e, f, z, n);
      out_ready = ordy;
      @(negedge clk);
      chk("in_ready", 16'(in_ready), 16'((occ < 2) || ordy));
      acc  = v && in_ready;
      fire = out_valid && ordy;
      @(posedge clk);
      if (acc) exp_q.push_back(cur_exp);
      occ = occ + int'(acc) - int'(fire);
      #1;
   endtask

   task automatic drain();
      bit acc;
      for (int i = 0; i < 20 && occ > 0; i++) step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, acc);
      chk("drain_occ", 16'(occ), 16'(0));
      chk("drain_queue", 16'(exp_q.size()), 16'(0));
   endtask

   initial begin
      bit acc, saw_block;
      int i, cyc;
      rst = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 16'(out_valid), 16'(0));
      chk("rst_out_posit", out_posit, 16'h0000);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 16'(in_ready), 16'(1));
      @(posedge clk);
      #1;

      directed("k0",       1'b0,   0, 0, 0,      1'b0, 1'b0, 16'h4000);
      directed("k1",       1'b0,   1, 0, 0,      1'b0, 1'b0, 16'h6000);
      directed("km1",      1'b0,  -1, 0, 0,      1'b0, 1'b0, 16'h2000);
      directed("e1",       1'b0,   0, 1, 0,      1'b0, 1'b0, 16'h5000);
      directed("neg_k0",   1'b1,   0, 0, 0,      1'b0, 1'b0, 16'hC000);
      directed("k14",      1'b0,  14, 0, 0,      1'b0, 1'b0, 16'h7FFF);
      directed("k20",      1'b0,  20, 0, 0,      1'b0, 1'b0, 16'h7FFF);
      directed("km14",     1'b0, -14, 0, 0,      1'b0, 1'b0, 16'h0001);
      directed("km14_ef",  1'b0, -14, 1, 'hFFFF, 1'b0, 1'b0, 16'h0001);
      directed("km20",     1'b0, -20, 0, 0,      1'b0, 1'b0, 16'h0001);
      directed("neg_k20",  1'b1,  20, 0, 0,      1'b0, 1'b0, 16'h8001);
      directed("tie_even", 1'b0,   0, 0, 'h0008, 1'b0, 1'b0, 16'h4000);
      directed("rnd_up",   1'b0,   0, 0, 'h0009, 1'b0, 1'b0, 16'h4001);
      directed("tie_odd",  1'b0,   0, 0, 'h0018, 1'b0, 1'b0, 16'h4002);
      directed("carry",    1'b0,   0, 0, 'hFFF8, 1'b0, 1'b0, 16'h5000);
      directed("no_wrap",  1'b0,  13, 1, 'h8000, 1'b0, 1'b0, 16'h7FFF);
      directed("nar",      1'b0,   0, 0, 0,      1'b1, 1'b1, 16'h8000);
      directed("zero",     1'b0,   5, 0, 0,      1'b1, 1'b0, 16'h0000);

      // Backpressure: four back-to-back words, out_ready low on cycles 1..3.
      i = 0;
      cyc = 0;
      saw_block = 1'b0;
      while (i < 4 && cyc < 20) begin
         step(1'b1, bit'(i & 1), i - 1, i & 1, i * 'h1111, 1'b0, 1'b0,
              !(cyc >= 1 && cyc <= 3), acc);
         if (acc) i++;
         else saw_block = 1'b1;
         cyc++;
      end
      chk("bp_all_accepted", 16'(i), 16'(4));
      chk("bp_ready_dropped", 16'(saw_block), 16'(1));
      drain();

      // Random traffic with random backpressure.
      for (int t = 0; t < 400; t++) begin
         step($urandom_range(0, 3) != 0, bit'($urandom_range(0, 1)),
              int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 1)),
              int'($urandom_range(0, 65535)), $urandom_range(0, 15) == 0,
              $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 7, acc);
      end
      drain();

      // Reset with both stages full: held words must vanish.
      step(1'b1, 1'b0, 2, 0, 0, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 1'b0, 3, 0, 0, 1'b0, 1'b0, 1'b0, acc);
      chk("rst_mid_full", 16'(occ), 16'(2));
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      occ = 0;
      @(negedge clk);
      chk("rst_mid_out_valid", 16'(out_valid), 16'(0));
      @(posedge clk);
      #1;
      directed("post_rst", 1'b0, 1, 0, 0, 1'b0, 1'b0, 16'h6000);
      repeat (3) @(posedge clk);
      chk("final_queue", 16'(exp_q.size()), 16'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
